// File: rtl/fabric_port_in_arbiter.sv
// rtl/fabric_port_in_arbiter.sv - packet-atomic round-robin arbiter feeding one fabric port input
module fabric_port_in_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 16,
    parameter int SRC_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk_slow,
    input  logic                       rst,
    input  logic [NUM_REQ*WIDTH-1:0]   i_data,
    input  logic [NUM_REQ-1:0]         i_valid,
    input  logic [NUM_REQ-1:0]         i_last,
    output logic [NUM_REQ-1:0]         i_ready,
    input  logic [NUM_REQ-1:0]         i_enable,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_valid,
    output logic                       o_last,
    output logic [SRC_W-1:0]           o_src,
    input  logic                       o_ready,
    output logic                       o_busy
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SRC_W-1:0]   r_grant;
    logic [SRC_W-1:0]   r_last_grant;
    logic [WIDTH-1:0]   r_o_data;
    logic               r_o_valid;
    logic               r_o_last;
    logic [SRC_W-1:0]   r_o_src;

    logic [NUM_REQ-1:0] w_cand;
    logic               w_any;
    logic [SRC_W-1:0]   w_pick;
    logic               w_space;
    logic               w_transfer;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic [WIDTH-1:0]   w_sel_data;

    assign w_cand     = i_valid & i_enable;
    assign w_space    = ~r_o_valid | o_ready;
    assign w_transfer = (r_state == ST_LOCKED) & w_sel_valid & w_space;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (r_grant == SRC_W'(k)) begin
                w_sel_valid = i_valid[k];
                w_sel_last  = i_last[k];
                w_sel_data  = i_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Wrap-around search: any candidate above last_grant beats every one at or below it,
    // and within each group the lowest index wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand[k] && (SRC_W'(k) <= r_last_grant)) begin
                w_any  = 1'b1;
                w_pick = SRC_W'(k);
            end
        end
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_cand[k] && (SRC_W'(k) > r_last_grant)) begin
                w_any  = 1'b1;
                w_pick = SRC_W'(k);
            end
        end
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        i_ready     = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    i_ready[k] = (r_grant == SRC_W'(k)) & w_space;
                end
                if (w_transfer && w_sel_last) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_slow) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= SRC_W'(NUM_REQ - 1);
            r_o_data     <= '0;
            r_o_valid    <= 1'b0;
            r_o_last     <= 1'b0;
            r_o_src      <= '0;
        end else begin
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant <= w_pick;
            end
            if (w_transfer) begin
                r_o_data  <= w_sel_data;
                r_o_last  <= w_sel_last;
                r_o_src   <= r_grant;
                r_o_valid <= 1'b1;
                if (w_sel_last) begin
                    r_last_grant <= r_grant;
                end
            end else if (o_ready) begin
                r_o_valid <= 1'b0;
            end
        end
    end

    assign o_data  = r_o_data;
    assign o_valid = r_o_valid;
    assign o_last  = r_o_last;
    assign o_src   = r_o_src;
    assign o_busy  = (r_state == ST_LOCKED);

endmodule

// File: tb/tb_fabric_port_in_arbiter.sv
// tb/tb_fabric_port_in_arbiter.sv - randomized bench for fabric_port_in_arbiter against a packet-level reference
module tb_fabric_port_in_arbiter;

    localparam int NR = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic              clk_slow = 1'b0;
    logic              rst;
    logic [NR*W-1:0]   i_data;
    logic [NR-1:0]     i_valid;
    logic [NR-1:0]     i_last;
    logic [NR-1:0]     i_ready;
    logic [NR-1:0]     i_enable;
    logic [W-1:0]      o_data;
    logic              o_valid;
    logic              o_last;
    logic [SW-1:0]     o_src;
    logic              o_ready;
    logic              o_busy;

    fabric_port_in_arbiter #(.NUM_REQ(NR), .WIDTH(W)) dut (
        .clk_slow (clk_slow),
        .rst      (rst),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .i_last   (i_last),
        .i_ready  (i_ready),
        .i_enable (i_enable),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .o_src    (o_src),
        .o_ready  (o_ready),
        .o_busy   (o_busy)
    );

    always #5 clk_slow = ~clk_slow;

    int n_pass  = 0;
    int n_total = 0;

    // Reference: who owns the port (-1 when nobody), who last finished, and the beat on the output.
    int          m_owner;
    int          m_last;
    bit          m_ov;
    bit          m_ol;
    logic [W-1:0] m_od;
    int          m_os;

    int          g_seq  [NR];
    int          g_left [NR];
    logic [W-1:0] sb    [NR][$];
    int          en_mode;
    int          grants [NR];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = NR - 1;
        m_ov    = 1'b0;
        m_ol    = 1'b0;
        m_od    = '0;
        m_os    = 0;
        for (int k = 0; k < NR; k++) begin
            g_left[k] = 0;
            sb[k].delete();
        end
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk_slow);
        rst     = 1'b1;
        i_valid = '0;
        i_last  = '0;
        o_ready = 1'b0;
        repeat (cycles) @(negedge clk_slow);
        check("rst_o_valid", 32'(o_valid), 32'd0);
        check("rst_o_data",  32'(o_data),  32'd0);
        check("rst_o_last",  32'(o_last),  32'd0);
        check("rst_o_src",   32'(o_src),   32'd0);
        check("rst_o_busy",  32'(o_busy),  32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic cycle(input int p_valid, input int p_ready);
        logic [NR-1:0] exp_rdy;
        bit            space;
        int            s;
        int            win;
        @(negedge clk_slow);
        check("o_valid", 32'(o_valid), 32'(m_ov));
        if (m_ov) begin
            check("o_data", 32'(o_data), 32'(m_od));
            check("o_last", 32'(o_last), 32'(m_ol));
            check("o_src",  32'(o_src),  32'(m_os));
        end
        check("o_busy", 32'(o_busy), 32'(m_owner >= 0));

        for (int k = 0; k < NR; k++) begin
            if (g_left[k] == 0) g_left[k] = $urandom_range(1, 4);
            i_valid[k]       = ($urandom_range(0, 99) < p_valid);
            i_data[k*W +: W] = {4'(k), 12'(g_seq[k])};
            i_last[k]        = (g_left[k] == 1);
        end
        o_ready = ($urandom_range(0, 99) < p_ready);
        if (en_mode == 2 && $urandom_range(0, 7) == 0) i_enable = 4'($urandom);
        #1;

        space = !m_ov || o_ready;
        for (int k = 0; k < NR; k++) exp_rdy[k] = (m_owner == k) && space;
        check("i_ready", 32'(i_ready), 32'(exp_rdy));

        if (o_valid && o_ready) begin
            s = int'(o_src);
            if (sb[s].size() == 0) check("sb_underflow", 32'd1, 32'd0);
            else check("sb_data", 32'(o_data), 32'(sb[s].pop_front()));
        end

        if (m_owner < 0) begin
            win = -1;
            for (int d = 1; d <= NR && win < 0; d++) begin
                s = (m_last + d) % NR;
                if (i_valid[s] && i_enable[s]) win = s;
            end
            if (win >= 0) begin
                m_owner = win;
                grants[win]++;
            end
            if (o_ready) m_ov = 1'b0;
        end else if (i_valid[m_owner] && space) begin
            s    = m_owner;
            m_od = i_data[s*W +: W];
            m_ol = i_last[s];
            m_os = s;
            m_ov = 1'b1;
            sb[s].push_back(m_od);
            g_seq[s]++;
            g_left[s]--;
            if (m_ol) begin
                m_last  = s;
                m_owner = -1;
            end
        end else if (o_ready) begin
            m_ov = 1'b0;
        end
    endtask

    initial begin
        rst      = 1'b1;
        i_data   = '0;
        i_valid  = '0;
        i_last   = '0;
        i_enable = '1;
        o_ready  = 1'b0;
        en_mode  = 0;
        for (int k = 0; k < NR; k++) begin
            g_seq[k]  = 0;
            grants[k] = 0;
        end
        model_reset();
        do_reset(4);

        repeat (200) cycle(100, 100);
        repeat (400) cycle(70, 50);
        do_reset(1);

        en_mode  = 1;
        i_enable = 4'b1011;
        for (int k = 0; k < NR; k++) grants[k] = 0;
        repeat (300) cycle(90, 80);
        check("masked_req2_grants", 32'(grants[2]), 32'd0);

        en_mode = 2;
        repeat (400) cycle(60, 60);
        do_reset(2);

        en_mode  = 0;
        i_enable = '1;
        repeat (300) cycle(100, 30);

        repeat (12) cycle(0, 100);
        for (int k = 0; k < NR; k++) check("sb_drained", 32'(sb[k].size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fabric_port_in_arbiter.md
# fabric_port_in_arbiter

Round-robin, packet-atomic arbiter that shares one fabric port input among NUM_REQ module-side requesters. Sits in the clk_slow domain directly upstream of the 4:1 TDM serializer. Grants one requester at a time, holds the grant until that requester's last beat is accepted, and presents the winner's beats through a single registered valid/ready output. A per-requester enable mask lets software idle a requester without breaking a packet in flight.

## Interface
- NUM_REQ, 4, number of requesters (2..16)
- WIDTH, 16, beat width in bits; must equal the TDM input width
- SRC_W, max(1, $clog2(NUM_REQ)), width of source index (derived)

- clk_slow  in  1  fabric-port slow clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- i_data  in  NUM_REQ*WIDTH  requester k beat at [k*WIDTH +: WIDTH]
- i_valid  in  NUM_REQ  per-requester beat valid
- i_last  in  NUM_REQ  per-requester last-beat-of-packet flag, qualified by i_valid
- i_ready  out  NUM_REQ  per-requester beat accepted this cycle when valid&ready
- i_enable  in  NUM_REQ  per-requester arbitration enable mask
- o_data  out  WIDTH  registered beat to TDM
- o_valid  out  1  registered beat valid
- o_last  out  1  registered last flag
- o_src  out  SRC_W  index of requester that produced the current o_data beat
- o_ready  in  1  downstream (TDM i_ready_out) ready
- o_busy  out  1  high while in LOCKED state

## Operation
- States: IDLE, LOCKED. Registers: grant (SRC_W), last_grant (SRC_W), output register {o_data,o_last,o_src,o_valid}.
- space = ~o_valid | o_ready. Output register loads on transfer; o_valid clears when o_ready & ~transfer.
- IDLE: candidates = i_valid & i_enable. If any, grant <= first candidate searching last_grant+1, +2, ... modulo NUM_REQ (wrap-around); go LOCKED. No beat transfers in IDLE. If none, stay IDLE.
- LOCKED: i_ready[k] = (k == grant) & space; all other i_ready = 0. Transfer = i_valid[grant] & i_ready[grant].
- On transfer: o_data <= granted slice, o_last <= i_last[grant], o_src <= grant, o_valid <= 1.
- On transfer with i_last[grant]=1: last_grant <= grant, go IDLE.
- i_enable[grant] deasserted in LOCKED has no effect until packet ends; mask is sampled only in IDLE.
- Granted requester dropping i_valid mid-packet: grant held indefinitely (no timeout), o_valid drains normally.
- Single-beat packet: first beat with i_last=1 ends lock same cycle it transfers.
- o_busy = (state == LOCKED).

## Timing
- Reset values: state IDLE, grant 0, last_grant NUM_REQ-1 (requester 0 has first priority), o_valid 0, o_last 0, o_src 0, o_data 0, i_ready all 0, o_busy 0.
- Reset mid-packet: partial packet abandoned; outputs return to reset values next cycle; requester must resend.
- Arbitration latency: request sampled in IDLE cycle N, i_ready[grant] can assert cycle N+1.
- Beat latency: requester beat accepted at edge N appears on o_data/o_valid from N to N+1 (one register stage).
- Throughput in LOCKED: one beat/cycle while o_ready=1. One dead cycle (IDLE) between consecutive packets, including back-to-back packets from the same requester.
- i_ready is combinational from state, grant, o_valid, o_ready; no combinational path from i_valid to i_ready.
- o_ready low with o_valid high: output register holds value; i_ready deasserted; no beat lost or duplicated.

## Test plan
- Single requester: rst 4 cycles, then req 2 sends 3 beats 0xA001,0xA002,0xA003 (last on 3rd), o_ready=1 -> grant=2 one cycle after valid, o_data sequence A001/A002/A003 on consecutive cycles, o_src=2, o_last only on A003, then o_busy=0.
- Round-robin fairness: all 4 requesters continuously send 2-beat packets -> grant order 0,1,2,3,0,... with exactly one idle cycle between packets; beats never interleaved.
- Backpressure: during 4-beat packet hold o_ready=0 for 3 cycles after beat 2 -> o_data stays beat 2, i_ready low, beats 3-4 follow intact; total beats out = 4.
- Mask: i_enable=4'b1011 with all requesting -> requester 2 never granted; clearing i_enable[1] mid-packet of req 1 -> packet completes, req 1 skipped afterward.
- Wrap and single-beat: last_grant=3, req 0 and 3 request 1-beat packets -> req 0 granted first, then 3; each lock lasts one transfer.
- Reset mid-packet: assert rst after beat 2 of 5 from req 1 -> next cycle o_valid=0, all i_ready=0, state IDLE, next grant goes to req 0 if requesting.
